// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared combinational ALU.
// One operation in flight at a time: accept (IDLE) -> drive ALU (EXEC) -> hold response (HOLD).
module alu_arbiter #(
  parameter int DW  = 32,
  parameter int OPW = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [OPW-1:0] req0_op,
  input  logic [DW-1:0]  req0_a,
  input  logic [DW-1:0]  req0_b,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [OPW-1:0] req1_op,
  input  logic [DW-1:0]  req1_a,
  input  logic [DW-1:0]  req1_b,
  output logic [OPW-1:0] alu_I,
  output logic [DW-1:0]  alu_op1,
  output logic [DW-1:0]  alu_op2,
  input  logic [DW-1:0]  alu_res1,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [DW-1:0]  rsp_data,
  output logic           rsp_id,
  output logic           rsp_err,
  output logic [15:0]    grant_cnt0,
  output logic [15:0]    grant_cnt1
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t         r_state;
  logic           r_last_grant;
  logic           r_id;
  logic           r_err;
  logic [OPW-1:0] r_alu_I;
  logic [DW-1:0]  r_alu_op1;
  logic [DW-1:0]  r_alu_op2;
  logic           r_rsp_valid;
  logic [DW-1:0]  r_rsp_data;
  logic           r_rsp_id;
  logic           r_rsp_err;
  logic [15:0]    r_grant_cnt0;
  logic [15:0]    r_grant_cnt1;

  logic           w_sel;
  logic           w_ready0;
  logic           w_ready1;
  logic           w_accept;
  logic [OPW-1:0] w_op;
  logic [DW-1:0]  w_a;
  logic [DW-1:0]  w_b;
  logic           w_legal;

  // A lone requester always wins; on a tie the one not granted last wins.
  assign w_sel    = (req0_valid & req1_valid) ? ~r_last_grant : ~req0_valid;
  assign w_ready0 = (r_state == IDLE) & ~rst & req0_valid & ~w_sel;
  assign w_ready1 = (r_state == IDLE) & ~rst & req1_valid &  w_sel;
  assign w_accept = w_ready0 | w_ready1;

  assign w_op    = w_sel ? req1_op : req0_op;
  assign w_a     = w_sel ? req1_a  : req0_a;
  assign w_b     = w_sel ? req1_b  : req0_b;
  assign w_legal = (w_op >= OPW'(1)) && (w_op <= OPW'(13));

  // Arbitration, ALU drive and response hold sequencing.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
      r_id         <= 1'b0;
      r_err        <= 1'b0;
      r_alu_I      <= '0;
      r_alu_op1    <= '0;
      r_alu_op2    <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_data   <= '0;
      r_rsp_id     <= 1'b0;
      r_rsp_err    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state      <= EXEC;
            r_alu_I      <= w_legal ? w_op : '0;
            r_alu_op1    <= w_a;
            r_alu_op2    <= w_b;
            r_id         <= w_sel;
            r_err        <= ~w_legal;
            r_last_grant <= w_sel;
          end
        end
        EXEC: begin
          r_state     <= HOLD;
          r_rsp_valid <= 1'b1;
          r_rsp_data  <= r_err ? '0 : alu_res1;
          r_rsp_id    <= r_id;
          r_rsp_err   <= r_err;
          r_alu_I     <= '0;
          r_alu_op1   <= '0;
          r_alu_op2   <= '0;
        end
        HOLD: begin
          if (rsp_ready) begin
            r_state     <= IDLE;
            r_rsp_valid <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Saturating per-requester acceptance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_grant_cnt0 <= 16'd0;
      r_grant_cnt1 <= 16'd0;
    end else begin
      if (w_ready0 && (r_grant_cnt0 != 16'hFFFF)) begin
        r_grant_cnt0 <= r_grant_cnt0 + 16'd1;
      end
      if (w_ready1 && (r_grant_cnt1 != 16'hFFFF)) begin
        r_grant_cnt1 <= r_grant_cnt1 + 16'd1;
      end
    end
  end

  assign req0_ready = w_ready0;
  assign req1_ready = w_ready1;
  assign alu_I      = r_alu_I;
  assign alu_op1    = r_alu_op1;
  assign alu_op2    = r_alu_op2;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_data   = r_rsp_data;
  assign rsp_id     = r_rsp_id;
  assign rsp_err    = r_rsp_err;
  assign grant_cnt0 = r_grant_cnt0;
  assign grant_cnt1 = r_grant_cnt1;

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter DW, default 32: operand/result width; only 32 is supported.
REQ-002 The block SHALL have parameter OPW, default 4: ALU opcode width.
REQ-003 The block SHALL have port clk, input, 1: the only clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 The block SHALL have ports req0_valid/req1_valid, input, 1 each: requester n presents an operation.
REQ-006 The block SHALL have ports req0_ready/req1_ready, output, 1 each: request n is accepted this cycle.
REQ-007 The block SHALL have ports req0_op/req1_op, input, OPW each: ALU opcode of request n.
REQ-008 The block SHALL have ports req0_a/req0_b/req1_a/req1_b, input, DW each: operands of request n.
REQ-009 The block SHALL have port alu_I, output, OPW: opcode driven to the shared ALU.
REQ-010 The block SHALL have ports alu_op1/alu_op2, output, DW each: operands driven to the shared ALU.
REQ-011 The block SHALL have port alu_res1, input, DW: combinational ALU result.
REQ-012 The block SHALL have port rsp_valid, output, 1: response holds a result.
REQ-013 The block SHALL have port rsp_ready, input, 1: consumer takes the response.
REQ-014 The block SHALL have ports rsp_data, output, DW; rsp_id, output, 1 (winning requester); rsp_err, output, 1 (illegal opcode).
REQ-015 The block SHALL have ports grant_cnt0/grant_cnt1, output, 16 each: saturating per-requester accept counters.

Function
REQ-016 The block SHALL implement FSM states IDLE, EXEC, HOLD.
REQ-017 In IDLE, the block SHALL assert reqN_ready only for the requester selected by round-robin among those with valid high; ready SHALL never be high for both requesters.
REQ-018 Round-robin: with both valid, the requester not granted last SHALL win; with one valid, it SHALL win regardless of history.
REQ-019 On acceptance (valid&ready), the block SHALL register op, a, b and id, update last_grant, and go to EXEC next cycle.
REQ-020 In EXEC, alu_I/alu_op1/alu_op2 SHALL equal the registered op/a/b; at the end of EXEC, alu_res1 SHALL be captured into rsp_data and the block SHALL go to HOLD.
REQ-021 Outside EXEC, alu_I, alu_op1 and alu_op2 SHALL be driven to 0.
REQ-022 Legal opcodes SHALL be 1..13; for op 0, 14 or 15, EXEC SHALL still occur with alu_I forced to 0, rsp_data SHALL be 0, and rsp_err SHALL be 1.
REQ-023 In HOLD, rsp_valid SHALL be 1 and rsp_data/rsp_id/rsp_err SHALL stay stable until rsp_valid&rsp_ready.
REQ-024 On response handshake, the block SHALL return to IDLE; a new request is accepted no earlier than the following cycle.
REQ-025 Latency: acceptance in cycle N gives rsp_valid in cycle N+2; minimum issue interval is 3 cycles.
REQ-026 reqN_ready SHALL be 0 in EXEC and HOLD; requester inputs are ignored there.
REQ-027 grant_cntN SHALL increment on each acceptance of requester N and saturate at 0xFFFF.

Reset
REQ-028 While rst=1 at a clock edge, the FSM SHALL go to IDLE, last_grant SHALL become 1 (requester 0 wins first tie), grant counters SHALL clear, and all outputs SHALL be 0.
REQ-029 Reset asserted in EXEC or HOLD SHALL abandon the in-flight operation with no response produced.

Verification
REQ-030 Req0 alone, op=1, a=5, b=7, rsp_ready=1: ready0 in cycle N -> alu_I=1 in N+1 -> rsp_valid, rsp_data=12, rsp_id=0 in N+2.
REQ-031 Both valid continuously, op=12 (a=3, b=9), rsp_ready=1 -> grants alternate 0,1,0,1; each rsp_data=1; grant counts equal.
REQ-032 Req1 op=2, a=2, b=3, rsp_ready=0 for 5 cycles -> rsp_data=0xFFFFFFFF held stable; ready0/ready1 stay 0 until the handshake.
REQ-033 Req0 op=15 -> rsp_err=1, rsp_data=0, alu_I=0 during EXEC.
REQ-034 rst pulsed during HOLD -> next cycle rsp_valid=0, counters 0; then both valid -> requester 0 granted first.
REQ-035 Force 65536 req0 grants -> grant_cnt0 stays at 0xFFFF.
